cm0ik_sram_init_ctrl: RTL and testbench



---
 rtl/cm0ik_sram_init_pkg.sv | 18 +
 rtl/cm0ik_sram_init_ctrl_if.sv | 28 ++
 rtl/cm0ik_sram_port_mux.sv | 20 ++
 rtl/cm0ik_sram_init_ctrl.sv | 94 +++++++++
 tb/tb_cm0ik_sram_init_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cm0ik_sram_init_pkg.sv
// Shared definitions for the SRAM power-up initialiser: controller state encoding
// and the port-ownership rule derived from it.
package cm0ik_sram_init_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  function automatic logic owns_port(state_t s);
    return (s == ST_FILL) || (s == ST_VERIFY);
  endfunction

endpackage

// File: rtl/cm0ik_sram_init_ctrl_if.sv
// Bridge-side and macro-side SRAM port bundle; master is the initialiser's view.
interface cm0ik_sram_init_ctrl_if #(
  parameter int AWIDTH = 12
);

  logic [AWIDTH-3:0] BRG_RAMAD;
  logic [31:0]       BRG_RAMWD;
  logic              BRG_RAMCS;
  logic [3:0]        BRG_RAMWE;
  logic [31:0]       BRG_RAMRD;

  logic [AWIDTH-3:0] RAMAD;
  logic [31:0]       RAMWD;
  logic              RAMCS;
  logic [3:0]        RAMWE;
  logic [31:0]       RAMRD;

  modport master (
    input  BRG_RAMAD, BRG_RAMWD, BRG_RAMCS, BRG_RAMWE, RAMRD,
    output BRG_RAMRD, RAMAD, RAMWD, RAMCS, RAMWE
  );

  modport slave (
    output BRG_RAMAD, BRG_RAMWD, BRG_RAMCS, BRG_RAMWE, RAMRD,
    input  BRG_RAMRD, RAMAD, RAMWD, RAMCS, RAMWE
  );

endinterface

// File: rtl/cm0ik_sram_port_mux.sv
// Zero-latency two-source SRAM port mux; select and strobes are gated off during reset.
module cm0ik_sram_port_mux #(
  parameter int AWIDTH = 12
) (
  input  logic                  HRESET,
  input  logic                  sel,
  input  logic [AWIDTH-3:0]     ctrl_ad,
  input  logic [31:0]           ctrl_wd,
  input  logic [3:0]            ctrl_we,
  cm0ik_sram_init_ctrl_if.master bus
);

  // Controller always selects the macro while it owns the port.
  assign bus.RAMCS     = ~HRESET & (sel | bus.BRG_RAMCS);
  assign bus.RAMWE     = HRESET ? '0 : (sel ? ctrl_we : bus.BRG_RAMWE);
  assign bus.RAMAD     = sel ? ctrl_ad : bus.BRG_RAMAD;
  assign bus.RAMWD     = sel ? ctrl_wd : bus.BRG_RAMWD;
  assign bus.BRG_RAMRD = bus.RAMRD;

endmodule

// File: rtl/cm0ik_sram_init_ctrl.sv
// Cortex-M0 kit SRAM initialiser: fills the array with PATTERN, optionally reads it
// back and checks it, then hands the port to the AHB bridge.
module cm0ik_sram_init_ctrl #(
  parameter int          AWIDTH    = 12,
  parameter logic [31:0] PATTERN   = 32'h0000_0000,
  parameter bit          VERIFY    = 1'b1,
  parameter bit          AUTO_INIT = 1'b1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   START,
  cm0ik_sram_init_ctrl_if.master bus,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   FAIL,
  output logic [AWIDTH-3:0]      FAIL_ADDR,
  output logic                   ACC_ERR
);
  import cm0ik_sram_init_pkg::*;

  localparam int     WA        = AWIDTH - 2;
  localparam state_t RST_STATE = AUTO_INIT ? ST_FILL : ST_IDLE;

  state_t          state;
  logic [WA-1:0]   cnt;
  logic            cnt_last;
  logic            rd_vld;
  logic [WA-1:0]   rd_addr;
  logic [3:0]      ctrl_we;

  assign cnt_last = &cnt;
  assign BUSY     = owns_port(state);
  assign ctrl_we  = (state == ST_FILL) ? 4'hF : 4'h0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= RST_STATE;
      cnt       <= '0;
      rd_vld    <= 1'b0;
      rd_addr   <= '0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      ACC_ERR   <= 1'b0;
    end else begin
      rd_vld  <= (state == ST_VERIFY);
      rd_addr <= cnt;
      if (BUSY && bus.BRG_RAMCS)
        ACC_ERR <= 1'b1;
      if (rd_vld && (bus.RAMRD != PATTERN) && !FAIL) begin
        FAIL      <= 1'b1;
        FAIL_ADDR <= rd_addr;
      end
      unique case (state)
        ST_IDLE: if (START) begin
          state     <= ST_FILL;
          cnt       <= '0;
          DONE      <= 1'b0;
          FAIL      <= 1'b0;
          FAIL_ADDR <= '0;
          ACC_ERR   <= 1'b0;
        end
        // Fill-only also passes through DRAIN so DONE always trails BUSY by one cycle.
        ST_FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt_last) begin
            cnt   <= '0;
            state <= VERIFY ? ST_VERIFY : ST_DRAIN;
          end
        end
        ST_VERIFY: begin
          cnt <= cnt + 1'b1;
          if (cnt_last)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
          DONE  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cm0ik_sram_port_mux #(.AWIDTH(AWIDTH)) u_port_mux (
    .HRESET  (HRESET),
    .sel     (BUSY),
    .ctrl_ad (cnt),
    .ctrl_wd (PATTERN),
    .ctrl_we (ctrl_we),
    .bus     (bus)
  );

endmodule

// File: tb/tb_cm0ik_sram_init_ctrl.sv
// Self-checking bench: two initialiser configurations against behavioural SRAM macros
// and a sequence-level expectation model.
module tb_cm0ik_sram_init_ctrl;

  localparam int          AW    = 6;
  localparam int          WA    = AW - 2;
  localparam int          N     = 1 << WA;
  localparam logic [31:0] PAT_A = 32'hA5C3_0F96;
  localparam logic [31:0] PAT_B = 32'h0000_0000;

  logic HCLK    = 1'b0;
  logic HRESET  = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, done_a, fail_a, acc_a;
  logic busy_b, done_b, fail_b, acc_b;
  logic [WA-1:0] fail_addr_a, fail_addr_b;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          acc_m;

  logic [31:0] mem_a     [N];
  logic [31:0] corrupt_a [N];
  logic [31:0] mem_b     [N];
  logic [31:0] ref_b     [N];

  cm0ik_sram_init_ctrl_if #(.AWIDTH(AW)) bus_a ();
  cm0ik_sram_init_ctrl_if #(.AWIDTH(AW)) bus_b ();

  cm0ik_sram_init_ctrl #(.AWIDTH(AW), .PATTERN(PAT_A), .VERIFY(1'b1), .AUTO_INIT(1'b1)) u_dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .START(start_a), .bus(bus_a.master),
    .BUSY(busy_a), .DONE(done_a), .FAIL(fail_a), .FAIL_ADDR(fail_addr_a), .ACC_ERR(acc_a)
  );

  cm0ik_sram_init_ctrl #(.AWIDTH(AW), .PATTERN(PAT_B), .VERIFY(1'b0), .AUTO_INIT(1'b0)) u_dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .START(start_b), .bus(bus_b.master),
    .BUSY(busy_b), .DONE(done_b), .FAIL(fail_b), .FAIL_ADDR(fail_addr_b), .ACC_ERR(acc_b)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // SRAM macros; macro A can return faulty bits on read.
  always @(posedge HCLK) begin
    if (bus_a.RAMCS) begin
      mem_a[bus_a.RAMAD] <= bmerge(mem_a[bus_a.RAMAD], bus_a.RAMWD, bus_a.RAMWE);
      bus_a.RAMRD        <= mem_a[bus_a.RAMAD] ^ corrupt_a[bus_a.RAMAD];
    end
    if (bus_b.RAMCS) begin
      mem_b[bus_b.RAMAD] <= bmerge(mem_b[bus_b.RAMAD], bus_b.RAMWD, bus_b.RAMWE);
      bus_b.RAMRD        <= mem_b[bus_b.RAMAD];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, act, exp);
  endtask

  task automatic next_cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic brg_a(input bit cs);
    bus_a.BRG_RAMCS = cs;
    bus_a.BRG_RAMAD = WA'($urandom);
    bus_a.BRG_RAMWD = $urandom;
    bus_a.BRG_RAMWE = 4'($urandom);
  endtask

  task automatic pulse_a();
    brg_a(1'b0);
    start_a = 1'b1;
    next_cyc();
    start_a = 1'b0;
  endtask

  // One controller-owned cycle of sequence A: k in 0..2N-1.
  task automatic a_cyc(input int k, input int noise, inout bit acc);
    bit cs;
    cs = (noise == 2) || (noise == 1 && $urandom_range(3) == 0);
    brg_a(cs);
    if (cs) acc = 1'b1;
    @(negedge HCLK);
    chk("a_busy", busy_a, 1);
    chk("a_ramcs", bus_a.RAMCS, 1);
    chk("a_ramwe", bus_a.RAMWE, (k < N) ? 4'hF : 4'h0);
    chk("a_ramad", bus_a.RAMAD, k % N);
    if (k < N) chk("a_ramwd", bus_a.RAMWD, PAT_A);
    chk("a_done_low", done_a, 0);
    if (k == 0) begin
      chk("a_fail_clr", fail_a, 0);
      chk("a_acc_clr", acc_a, 0);
    end
    next_cyc();
  endtask

  task automatic seq_a(input int noise);
    bit acc = 1'b0;
    bit f   = 1'b0;
    int fa  = 0;
    int ra;
    // Reads go up from address 0, so the first mismatch is the lowest faulty address.
    for (int a = N - 1; a >= 0; a--)
      if (corrupt_a[a] != 0) begin
        f  = 1'b1;
        fa = a;
      end
    for (int k = 0; k < 2 * N; k++) a_cyc(k, noise, acc);
    ra = int'($urandom_range(N - 1));
    bus_a.BRG_RAMCS = 1'b1;
    bus_a.BRG_RAMWE = 4'h0;
    bus_a.BRG_RAMAD = WA'(ra);
    @(negedge HCLK);
    chk("a_drain_busy", busy_a, 0);
    chk("a_drain_done", done_a, 0);
    chk("a_drain_ramcs", bus_a.RAMCS, 1);
    chk("a_drain_ramwe", bus_a.RAMWE, 0);
    chk("a_drain_ramad", bus_a.RAMAD, ra);
    next_cyc();
    bus_a.BRG_RAMCS = 1'b0;
    @(negedge HCLK);
    chk("a_done", done_a, 1);
    chk("a_idle_busy", busy_a, 0);
    chk("a_fail", fail_a, f);
    chk("a_fail_addr", fail_addr_a, fa);
    chk("a_acc_err", acc_a, acc);
    chk("a_drain_rd", bus_a.BRG_RAMRD, PAT_A ^ corrupt_a[ra]);
    next_cyc();
  endtask

  task automatic b_write(input int ad, input logic [31:0] wd, input logic [3:0] we);
    bus_b.BRG_RAMCS = 1'b1;
    bus_b.BRG_RAMAD = WA'(ad);
    bus_b.BRG_RAMWD = wd;
    bus_b.BRG_RAMWE = we;
    @(negedge HCLK);
    chk("b_pt_cs", bus_b.RAMCS, 1);
    chk("b_pt_ad", bus_b.RAMAD, ad);
    chk("b_pt_wd", bus_b.RAMWD, wd);
    chk("b_pt_we", bus_b.RAMWE, we);
    next_cyc();
    bus_b.BRG_RAMCS = 1'b0;
    ref_b[ad] = bmerge(ref_b[ad], wd, we);
  endtask

  task automatic b_read(input int ad);
    bus_b.BRG_RAMCS = 1'b1;
    bus_b.BRG_RAMAD = WA'(ad);
    bus_b.BRG_RAMWE = 4'h0;
    @(negedge HCLK);
    chk("b_rd_cs", bus_b.RAMCS, 1);
    chk("b_rd_ad", bus_b.RAMAD, ad);
    next_cyc();
    bus_b.BRG_RAMCS = 1'b0;
    @(negedge HCLK);
    chk("b_rd_data", bus_b.BRG_RAMRD, ref_b[ad]);
    next_cyc();
  endtask

  initial begin
    for (int a = 0; a < N; a++) corrupt_a[a] = '0;
    brg_a(1'b0);
    bus_b.BRG_RAMCS = 1'b0;
    bus_b.BRG_RAMAD = '0;
    bus_b.BRG_RAMWD = '0;
    bus_b.BRG_RAMWE = '0;
    #1 HRESET = 1'b1;
    repeat (2) next_cyc();

    // Reset state, with the bridge actively requesting to prove the gating.
    bus_a.BRG_RAMCS = 1'b1;
    bus_a.BRG_RAMWE = 4'hF;
    bus_b.BRG_RAMCS = 1'b1;
    @(negedge HCLK);
    chk("rst_a_busy", busy_a, 1);
    chk("rst_a_done", done_a, 0);
    chk("rst_a_fail", fail_a, 0);
    chk("rst_a_fail_addr", fail_addr_a, 0);
    chk("rst_a_acc", acc_a, 0);
    chk("rst_a_ramcs", bus_a.RAMCS, 0);
    chk("rst_a_ramwe", bus_a.RAMWE, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_ramcs", bus_b.RAMCS, 0);
    next_cyc();
    bus_b.BRG_RAMCS = 1'b0;
    HRESET = 1'b0;

    // Auto-init after reset release, clean array.
    seq_a(0);

    // Directed faults at 9 and 12; bridge hammers the port throughout.
    corrupt_a[9]  = 32'h0000_0008;
    corrupt_a[12] = 32'h1 << $urandom_range(31);
    pulse_a();
    seq_a(2);

    // Randomised fault maps and bridge noise.
    for (int r = 0; r < 4; r++) begin
      int nc;
      for (int a = 0; a < N; a++) corrupt_a[a] = '0;
      nc = int'($urandom_range(2));
      for (int j = 0; j < nc; j++)
        corrupt_a[$urandom_range(N - 1)] = $urandom | (32'h1 << $urandom_range(31));
      repeat ($urandom_range(3)) next_cyc();
      pulse_a();
      seq_a(1);
    end

    // Reset mid-VERIFY when the counter reaches 5.
    for (int a = 0; a < N; a++) corrupt_a[a] = '0;
    corrupt_a[2] = 32'h0000_0100;
    acc_m = 1'b0;
    pulse_a();
    for (int k = 0; k < N + 5; k++) a_cyc(k, 2, acc_m);
    chk("mid_fail_pre", fail_a, 1);
    chk("mid_acc_pre", acc_a, acc_m);
    chk("mid_ramad_pre", bus_a.RAMAD, 5);
    HRESET = 1'b1;
    #1;
    chk("mid_ramcs", bus_a.RAMCS, 0);
    chk("mid_ramwe", bus_a.RAMWE, 0);
    chk("mid_fail", fail_a, 0);
    chk("mid_fail_addr", fail_addr_a, 0);
    chk("mid_acc", acc_a, 0);
    chk("mid_done", done_a, 0);
    chk("mid_busy", busy_a, 1);
    next_cyc();
    HRESET = 1'b0;
    corrupt_a[2] = '0;
    seq_a(0);

    // Fill-only configuration driven by START; a second START mid-fill is ignored.
    start_b = 1'b1;
    next_cyc();
    start_b = 1'b0;
    for (int k = 0; k < N; k++) begin
      start_b = (k == 5);
      @(negedge HCLK);
      chk("b_busy", busy_b, 1);
      chk("b_ramcs", bus_b.RAMCS, 1);
      chk("b_ramwe", bus_b.RAMWE, 4'hF);
      chk("b_ramad", bus_b.RAMAD, k);
      chk("b_ramwd", bus_b.RAMWD, PAT_B);
      next_cyc();
    end
    start_b = 1'b0;
    @(negedge HCLK);
    chk("b_tail_busy", busy_b, 0);
    chk("b_tail_done", done_b, 0);
    next_cyc();
    @(negedge HCLK);
    chk("b_done", done_b, 1);
    chk("b_idle_busy", busy_b, 0);
    chk("b_fail", fail_b, 0);
    next_cyc();
    @(negedge HCLK);
    chk("b_no_restart", busy_b, 0);
    next_cyc();

    for (int a = 0; a < N; a++) ref_b[a] = PAT_B;
    b_write(7, 32'hDEAD_BEEF, 4'h3);
    bus_b.BRG_RAMCS = 1'b1;
    bus_b.BRG_RAMAD = WA'(7);
    bus_b.BRG_RAMWE = 4'h0;
    next_cyc();
    bus_b.BRG_RAMCS = 1'b0;
    @(negedge HCLK);
    chk("b_rd7", bus_b.BRG_RAMRD, 32'h0000_BEEF);
    next_cyc();

    // Random pass-through traffic against the reference array.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1) == 1)
        b_write(int'($urandom_range(N - 1)), $urandom, 4'($urandom));
      else
        b_read(int'($urandom_range(N - 1)));
    end
    chk("b_acc_err", acc_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
